cas_sort_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-input compare-and-swap sorter.
- Sorts NUM_INPUTS unsigned SNG_WIDTH-bit values with a bitonic compare-and-swap network and a register after every network stage.
- Direction is selectable per sample. Valid/ready handshake on both sides.
- Sits between the SNG value generators and the downstream max/min/median selection logic; accepts one sample set per cycle.

---
 rtl/cas_sort_pipe.sv | 179 +++++++++++++++++
 tb/tb_cas_sort_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_sort_pipe.sv
// Pipelined bitonic compare-and-swap sorter: NUM_INPUTS unsigned lanes, one register bank per network stage.
// Optional macro CAS_SORT_INDEX_EN adds out_idx, the original lane number carried with each sorted value.
module cas_sort_pipe #(
    parameter int SNG_WIDTH  = 4,
    parameter int NUM_INPUTS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0] in_data,
    input  logic                            in_dir,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0] out_data
`ifdef CAS_SORT_INDEX_EN
    ,
    output logic [NUM_INPUTS*$clog2(NUM_INPUTS)-1:0] out_idx
`endif
);

    localparam int LOG_N      = $clog2(NUM_INPUTS);
    localparam int NUM_STAGES = LOG_N * (LOG_N + 1) / 2;
    localparam int DW         = NUM_INPUTS * SNG_WIDTH;

    if (NUM_INPUTS < 2 || NUM_INPUTS > 16 || (1 << LOG_N) != NUM_INPUTS) begin : g_bad_param
        $error("cas_sort_pipe: NUM_INPUTS must be a power of two in 2..16");
    end

    // Network stage s belongs to merge block size 2^kl and compares lanes 2^jl apart.
    function automatic int stage_kl(input int s);
        int c;
        int r;
        c = 0;
        r = 0;
        for (int a = 1; a <= LOG_N; a++) begin
            for (int b = a - 1; b >= 0; b--) begin
                if (c == s) r = a;
                c = c + 1;
            end
        end
        return r;
    endfunction

    function automatic int stage_jl(input int s);
        int c;
        int r;
        c = 0;
        r = 0;
        for (int a = 1; a <= LOG_N; a++) begin
            for (int b = a - 1; b >= 0; b--) begin
                if (c == s) r = b;
                c = c + 1;
            end
        end
        return r;
    endfunction

    // Lower lane of comparator p: insert a zero bit at position jl of p.
    function automatic int pair_lo(input int s, input int p);
        int jl;
        jl = stage_jl(s);
        return ((p >> jl) << (jl + 1)) | (p & ((1 << jl) - 1));
    endfunction

    logic [DW-1:0] data_d [0:NUM_STAGES];
    logic [DW-1:0] data_q [0:NUM_STAGES];
    logic          dir_d  [0:NUM_STAGES];
    logic          dir_q  [0:NUM_STAGES];
    logic          vld_d  [0:NUM_STAGES];
    logic          vld_q  [0:NUM_STAGES];
`ifdef CAS_SORT_INDEX_EN
    logic [NUM_INPUTS*LOG_N-1:0] idx_d [0:NUM_STAGES];
    logic [NUM_INPUTS*LOG_N-1:0] idx_q [0:NUM_STAGES];
`endif

    logic                 advance;
    logic [SNG_WIDTH-1:0] cas_a;
    logic [SNG_WIDTH-1:0] cas_b;
    logic                 cas_up;
    logic                 cas_swap;
    int                   lo;
    int                   hi;

    // Global stall: everything moves together or nothing moves.
    always_comb begin
        advance = !vld_q[NUM_STAGES] || out_ready;
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[NUM_STAGES];
    assign out_data  = data_q[NUM_STAGES];
`ifdef CAS_SORT_INDEX_EN
    assign out_idx   = idx_q[NUM_STAGES];
`endif

    // Next-state of every bank: bank 0 takes the raw sample, bank s+1 is network stage s applied to bank s.
    always_comb begin
        cas_a    = '0;
        cas_b    = '0;
        cas_up   = 1'b0;
        cas_swap = 1'b0;
        lo       = 0;
        hi       = 0;
        data_d[0] = in_data;
        dir_d[0]  = in_dir;
        vld_d[0]  = in_valid;
`ifdef CAS_SORT_INDEX_EN
        for (int i = 0; i < NUM_INPUTS; i++) begin
            idx_d[0][i*LOG_N +: LOG_N] = LOG_N'(i);
        end
`endif
        for (int s = 0; s < NUM_STAGES; s++) begin
            data_d[s+1] = data_q[s];
            dir_d[s+1]  = dir_q[s];
            vld_d[s+1]  = vld_q[s];
`ifdef CAS_SORT_INDEX_EN
            idx_d[s+1]  = idx_q[s];
`endif
            for (int p = 0; p < NUM_INPUTS / 2; p++) begin
                lo    = pair_lo(s, p);
                hi    = lo + (1 << stage_jl(s));
                cas_a = data_q[s][lo*SNG_WIDTH +: SNG_WIDTH];
                cas_b = data_q[s][hi*SNG_WIDTH +: SNG_WIDTH];
                // Sub-blocks alternate direction; the final merge block always follows the sample's dir.
                cas_up   = (((lo >> stage_kl(s)) & 1) == 0) ? dir_q[s] : !dir_q[s];
                cas_swap = cas_up ? (cas_a > cas_b) : (cas_a < cas_b);
                if (cas_swap) begin
                    data_d[s+1][lo*SNG_WIDTH +: SNG_WIDTH] = cas_b;
                    data_d[s+1][hi*SNG_WIDTH +: SNG_WIDTH] = cas_a;
`ifdef CAS_SORT_INDEX_EN
                    idx_d[s+1][lo*LOG_N +: LOG_N] = idx_q[s][hi*LOG_N +: LOG_N];
                    idx_d[s+1][hi*LOG_N +: LOG_N] = idx_q[s][lo*LOG_N +: LOG_N];
`endif
                end else begin
                    data_d[s+1][lo*SNG_WIDTH +: SNG_WIDTH] = cas_a;
                    data_d[s+1][hi*SNG_WIDTH +: SNG_WIDTH] = cas_b;
`ifdef CAS_SORT_INDEX_EN
                    idx_d[s+1][lo*LOG_N +: LOG_N] = idx_q[s][lo*LOG_N +: LOG_N];
                    idx_d[s+1][hi*LOG_N +: LOG_N] = idx_q[s][hi*LOG_N +: LOG_N];
`endif
                end
            end
        end
    end

    // Pipeline banks: cleared by reset, shifted on advance, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_STAGES; i++) begin
                data_q[i] <= '0;
                dir_q[i]  <= 1'b0;
                vld_q[i]  <= 1'b0;
`ifdef CAS_SORT_INDEX_EN
                idx_q[i]  <= '0;
`endif
            end
        end else if (advance) begin
            for (int i = 0; i <= NUM_STAGES; i++) begin
                data_q[i] <= data_d[i];
                dir_q[i]  <= dir_d[i];
                vld_q[i]  <= vld_d[i];
`ifdef CAS_SORT_INDEX_EN
                idx_q[i]  <= idx_d[i];
`endif
            end
        end else begin
            for (int i = 0; i <= NUM_STAGES; i++) begin
                data_q[i] <= data_q[i];
                dir_q[i]  <= dir_q[i];
                vld_q[i]  <= vld_q[i];
`ifdef CAS_SORT_INDEX_EN
                idx_q[i]  <= idx_q[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_cas_sort_pipe.sv
// Self-checking bench for cas_sort_pipe (4 lanes x 4 bits); checks against a plain sorting reference and a FIFO scoreboard.
module tb_cas_sort_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef CAS_SORT_INDEX_EN
    logic [7:0]  out_idx;
    logic [7:0]  got_idx_q[$];
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [15:0] inp_q[$];
    logic [15:0] got_q[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = 16'h0;

    cas_sort_pipe #(.SNG_WIDTH(4), .NUM_INPUTS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef CAS_SORT_INDEX_EN
        , .out_idx(out_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] pack4(input logic [3:0] l0, input logic [3:0] l1,
                                          input logic [3:0] l2, input logic [3:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference: plain bubble sort of the four lane values.
    function automatic logic [15:0] ref_sort(input logic [15:0] d, input logic dir);
        logic [3:0] v[4];
        logic [3:0] t;
        logic [15:0] r;
        for (int i = 0; i < 4; i++) v[i] = d[i*4 +: 4];
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3 - i; j++) begin
                if (dir ? (v[j] > v[j+1]) : (v[j] < v[j+1])) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        r = 16'h0;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = v[i];
        return r;
    endfunction

    // Compare process: handshake rules, stall stability, and in-order scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'(1'b1));
                check("stall_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h expected no output", out_data);
                end else begin
                    logic [15:0] e;
                    logic [15:0] src;
                    e   = exp_q.pop_front();
                    src = inp_q.pop_front();
                    check("sorted_data", 64'(out_data), 64'(e));
`ifdef CAS_SORT_INDEX_EN
                    begin
                        logic [3:0]  seen;
                        logic [15:0] recon;
                        seen  = 4'h0;
                        recon = 16'h0;
                        for (int j = 0; j < 4; j++) begin
                            seen[out_idx[j*2 +: 2]] = 1'b1;
                            recon[j*4 +: 4] = src[out_idx[j*2 +: 2]*4 +: 4];
                        end
                        check("idx_perm", 64'(seen), 64'(4'hF));
                        check("idx_value", 64'(recon), 64'(out_data));
                        got_idx_q.push_back(out_idx);
                    end
`endif
                end
                got_q.push_back(out_data);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sort(in_data, in_dir));
                inp_q.push_back(in_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one sample and returns #1 after the edge that accepted it; in_valid is left high.
    task automatic send(input logic [15:0] d, input logic dir);
        int  n;
        logic done;
        in_data  = d;
        in_dir   = dir;
        in_valid = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else begin
                n++;
                if (n > 100) begin
                    check("send_timeout", 64'(n), 64'(0));
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        tick(2);
        check("reset_out_valid", 64'(out_valid), 64'(1'b0));
        check("reset_out_data", 64'(out_data), 64'(16'h0));
        check("reset_in_ready", 64'(in_ready), 64'(1'b1));
        rst_n = 1'b1;
        tick(1);

        // Model pins: hand-sorted literals.
        check("model_desc", 64'(ref_sort(pack4(4'd3, 4'd9, 4'd9, 4'd1), 1'b0)), 64'(16'h1399));
        check("model_asc", 64'(ref_sort(pack4(4'd3, 4'd9, 4'd9, 4'd1), 1'b1)), 64'(16'h9931));

        // Single descending sample: exact latency of 3 edges.
        send(pack4(4'd3, 4'd9, 4'd9, 4'd1), 1'b0);
        in_valid = 1'b0;
        tick(2);
        check("lat_early", 64'(out_valid), 64'(1'b0));
        tick(1);
        check("lat_valid", 64'(out_valid), 64'(1'b1));
        check("desc_data", 64'(out_data), 64'(16'h1399));
        tick(1);
        check("lat_after", 64'(out_valid), 64'(1'b0));

        // Ascending, back-to-back mixed directions, boundary values.
        got_q.delete();
        send(pack4(4'd3, 4'd9, 4'd9, 4'd1), 1'b1);
        send(pack4(4'd15, 4'd0, 4'd15, 4'd0), 1'b0);
        send(pack4(4'd2, 4'd2, 4'd2, 4'd2), 1'b1);
        send(pack4(4'd0, 4'd15, 4'd0, 4'd15), 1'b0);
        in_valid = 1'b0;
        tick(6);
        check("b2b_count", 64'(got_q.size()), 64'(4));
        check("asc_data", 64'(got_q[0]), 64'(16'h9931));
        check("b2b_first", 64'(got_q[1]), 64'(16'h00FF));
        check("all_equal", 64'(got_q[2]), 64'(16'h2222));
        check("boundary", 64'(got_q[3]), 64'(16'h00FF));

`ifdef CAS_SORT_INDEX_EN
        got_idx_q.delete();
        got_q.delete();
        send(pack4(4'd5, 4'd0, 4'd15, 4'd7), 1'b0);
        in_valid = 1'b0;
        tick(5);
        check("idx_count", 64'(got_idx_q.size()), 64'(1));
        check("idx_data", 64'(got_q[0]), 64'(16'h057F));
        check("idx_lanes", 64'(got_idx_q[0]), 64'(8'h4E));
`endif

        // Backpressure: 6 samples, out_ready low for cycles 4..7.
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(pack4(4'(i), 4'(5 - i), 4'(i * 2), 4'd7), i[0]);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 4 && c <= 7);
                    tick(1);
                end
                out_ready = 1'b1;
            end
        join
        tick(8);
        check("bp_count", 64'(got_q.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            check("bp_order", 64'(got_q[i]), 64'(ref_sort(pack4(4'(i), 4'(5 - i), 4'(i * 2), 4'd7), i[0])));
        end

        // Reset with two samples in flight, the oldest stalled at the output.
        got_q.delete();
        out_ready = 1'b0;
        send(pack4(4'd1, 4'd2, 4'd3, 4'd4), 1'b0);
        send(pack4(4'd8, 4'd7, 4'd6, 4'd5), 1'b1);
        in_valid = 1'b0;
        tick(2);
        check("pre_reset_valid", 64'(out_valid), 64'(1'b1));
        rst_n = 1'b0;
        exp_q.delete();
        inp_q.delete();
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(1'b0));
        check("async_rst_data", 64'(out_data), 64'(16'h0));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(8);
        check("no_ghost_out", 64'(got_q.size()), 64'(0));

        // Random run: 10000 accepted samples under random valid/ready.
        begin
            int sent;
            int cyc;
            sent = 0;
            cyc  = 0;
            while (sent < 10000 && cyc < 60000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = 16'($urandom);
                in_dir    = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (in_valid && in_ready) sent++;
                @(posedge clk);
                #1;
                cyc++;
            end
            check("random_sent", 64'(sent), 64'(10000));
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick(10);
            check("random_drain", 64'(exp_q.size()), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
